key_bus_encoder: RTL and testbench
==================================

KEY_BUS_ENCODER -- requirements
Module: key_bus_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2000000 (20 ms at 100 MHz); number of consecutive stable cycles before an input change is accepted; legal range 2..2^21-1.
REQ-002 clk  input  1  single system clock; all logic on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 note_sw  input  7  raw, asynchronous note switches; bit k selects note k+1 (bit 0 = do ... bit 6 = si).
REQ-005 oct_up_btn  input  1  raw, asynchronous octave-up push button.
REQ-006 oct_down_btn  input  1  raw, asynchronous octave-down push button.
REQ-007 busline  output  10  registered note bus: [9:3] one-hot note field, [2:0] one-hot octave field.
REQ-008 note_valid  output  1  registered; high when busline[9:3] is non-zero.
REQ-009 note_change  output  1  registered one-cycle pulse; high in the cycle busline changes value.

Function
REQ-010 Every raw input SHALL pass through a two-flop synchronizer, then a debouncer; the debounced value updates only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-011 The debounce counter SHALL clear on any cycle where the synchronized value equals the debounced value; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-012 Note mapping: debounced note bit k asserted SHALL drive busline[3+k]; busline[9] = si (note 7), busline[3] = do (note 1).
REQ-013 With several debounced note bits high, the lowest index SHALL win; busline[9:3] SHALL never have more than one bit set.
REQ-014 With no debounced note bits high, busline[9:3] SHALL be 7'b0 and note_valid SHALL be 0.
REQ-015 Octave FSM states: LOW (code 3'b001), MID (3'b010), HIGH (3'b100); busline[2:0] SHALL equal the current state code.
REQ-016 The rising edge of debounced oct_up SHALL step LOW->MID->HIGH; in HIGH it SHALL hold (saturate, no wrap).
REQ-017 The rising edge of debounced oct_down SHALL step HIGH->MID->LOW; in LOW it SHALL hold.
REQ-018 A hold on either button SHALL produce exactly one step; falling edges SHALL be ignored.
REQ-019 When the up and down rising edges occur in the same cycle, the state SHALL be unchanged.
REQ-020 Latency: busline SHALL update exactly one cycle after the debounced value changes; total raw-to-bus latency is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-021 note_change SHALL be asserted in the first cycle in which the new busline value is visible, for one cycle only; it SHALL NOT be asserted when the value is unchanged.
REQ-022 Octave changes SHALL apply to the held note immediately; the note field SHALL be unaffected.

Reset
REQ-023 While rst is high: busline = 10'b0000000_010 (no note, MID), note_valid = 0, note_change = 0.
REQ-024 Reset SHALL clear all synchronizer, debouncer and counter state to 0 (inputs treated as released).
REQ-025 A reset asserted mid-debounce or mid-press SHALL discard the pending change; a button still held at reset release SHALL count as a new press after DEBOUNCE_CYCLES.

Structure
REQ-026 A shared package SHALL hold the octave state codes (LOW/MID/HIGH), the note field width (7), the octave field width (3), the bus width (10), and the busline bit-slice positions.
REQ-027 One sub-module, debounce (synchronizer plus counter, parameterised by DEBOUNCE_CYCLES), SHALL be instantiated once per raw input (9 instances).
REQ-028 The priority encoder and the octave FSM SHALL live in key_bus_encoder; the busline field layout SHALL match the LED decoder exactly.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset; release rst -> busline=10'b0000000010, note_valid=0, note_change=0.
REQ-030 Hold note_sw=7'b0000001 -> busline=10'b0000001010 exactly 7 cycles after the input edge; a single note_change pulse; note_valid=1.
REQ-031 Pulse note_sw[3] high for 3 cycles -> busline unchanged and no note_change.
REQ-032 Hold note_sw=7'b1000100 -> busline[9:3]=7'b0000100 (lowest index wins).
REQ-033 Three separate oct_up presses from MID -> codes 100, 100, 100 (saturate); each 1000-cycle hold gives one step; two oct_down presses -> 010, then 001.
REQ-034 oct_up and oct_down pressed on the same cycle -> octave unchanged; rst asserted during a pending note debounce -> busline=10'b0000000010 after reset.

Source files
------------

// File: rtl/key_bus_encoder_pkg.sv
// ---------------------------------------------------------------------------
// key_bus_encoder_pkg
// Shared definitions for the key-to-note-bus encoder: field widths, the
// busline bit-slice layout (which must match the LED decoder), the octave
// state codes and a small lowest-set-bit helper for the note field.
// ---------------------------------------------------------------------------
package key_bus_encoder_pkg;

    // Field widths of the note bus
    localparam int NOTE_W = 7;
    localparam int OCT_W  = 3;
    localparam int BUS_W  = NOTE_W + OCT_W;

    // busline layout: [9:3] one-hot note, [2:0] one-hot octave
    localparam int NOTE_LSB = OCT_W;
    localparam int NOTE_MSB = BUS_W - 1;
    localparam int OCT_LSB  = 0;
    localparam int OCT_MSB  = OCT_W - 1;

    // Debounce counter width; wide enough for DEBOUNCE_CYCLES up to 2^21-1
    localparam int DEB_CNT_W = 21;

    // Octave states double as the one-hot octave field of the bus
    typedef enum logic [OCT_W-1:0] {
        OCT_LOW  = 3'b001,
        OCT_MID  = 3'b010,
        OCT_HIGH = 3'b100
    } octave_e;

    // Keep only the lowest set bit: x & (two's complement of x)
    function automatic logic [NOTE_W-1:0] lowest_note(input logic [NOTE_W-1:0] sw);
        return sw & (~sw + {{(NOTE_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/key_bus_encoder_debounce.sv
// ---------------------------------------------------------------------------
// key_bus_encoder_debounce
// Two-flop synchronizer followed by a counter debouncer for one raw,
// asynchronous switch or button.  The debounced level only follows the
// synchronized input after it has disagreed for DEBOUNCE_CYCLES consecutive
// cycles; any cycle of agreement restarts the count.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset (clears all state to released)
//   raw   - raw asynchronous input
//   level - debounced, synchronous level
// ---------------------------------------------------------------------------
module key_bus_encoder_debounce
    import key_bus_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000
)
(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    // The count that completes a run of DEBOUNCE_CYCLES disagreeing samples
    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync_a;
    logic                 sync_b;
    logic [DEB_CNT_W-1:0] count;

    // Metastability guard for the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // A one-bit input that disagrees with level is necessarily stable at the
    // opposite value, so counting disagreement cycles counts a stable run.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync_b == level) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            level <= sync_b;
            count <= '0;
        end else begin
            count <= count + DEB_CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_bus_encoder.sv
// ---------------------------------------------------------------------------
// key_bus_encoder
// Turns seven note switches and two octave push buttons into a registered
// 10-bit note bus for the LED decoder.  Every raw input is synchronized and
// debounced; the note field carries the lowest-index pressed note, the
// octave field carries the one-hot state of a saturating LOW/MID/HIGH FSM.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   note_sw      - raw note switches, bit k = note k+1 (do .. si)
//   oct_up_btn   - raw octave-up button
//   oct_down_btn - raw octave-down button
//   busline      - [9:3] one-hot note, [2:0] one-hot octave (registered)
//   note_valid   - registered, high while a note is present on the bus
//   note_change  - registered one-cycle pulse when busline takes a new value
// ---------------------------------------------------------------------------
module key_bus_encoder
    import key_bus_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note_sw,
    input  logic              oct_up_btn,
    input  logic              oct_down_btn,
    output logic [BUS_W-1:0]  busline,
    output logic              note_valid,
    output logic              note_change
);

    logic [NOTE_W-1:0] note_level;
    logic              up_level;
    logic              down_level;
    logic              up_prev;
    logic              down_prev;
    logic              up_rise;
    logic              down_rise;
    octave_e           oct_state;
    octave_e           oct_next;
    logic [NOTE_W-1:0] note_next;
    logic [BUS_W-1:0]  bus_next;

    // One debouncer per note switch
    for (genvar k = 0; k < NOTE_W; k++) begin : g_note_deb
        key_bus_encoder_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_note_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (note_sw[k]),
            .level (note_level[k])
        );
    end

    key_bus_encoder_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (oct_up_btn),
        .level (up_level)
    );

    key_bus_encoder_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_down_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (oct_down_btn),
        .level (down_level)
    );

    // Octave state and the previous debounced button levels for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            oct_state <= OCT_MID;
            up_prev   <= 1'b0;
            down_prev <= 1'b0;
        end else begin
            oct_state <= oct_next;
            up_prev   <= up_level;
            down_prev <= down_level;
        end
    end

    // Only rising edges step the octave, so a held button moves it once.
    // Simultaneous up and down edges cancel out.
    always_comb begin
        up_rise   = up_level & ~up_prev;
        down_rise = down_level & ~down_prev;
        oct_next  = oct_state;
        if (up_rise && !down_rise) begin
            case (oct_state)
                OCT_LOW: oct_next = OCT_MID;
                OCT_MID: oct_next = OCT_HIGH;
                default: oct_next = OCT_HIGH;
            endcase
        end else if (down_rise && !up_rise) begin
            case (oct_state)
                OCT_HIGH: oct_next = OCT_MID;
                OCT_MID:  oct_next = OCT_LOW;
                default:  oct_next = OCT_LOW;
            endcase
        end
    end

    // Next bus value; the octave field uses oct_next so it stays equal to the
    // registered state once both are clocked.
    always_comb begin
        note_next                   = lowest_note(note_level);
        bus_next                    = '0;
        bus_next[NOTE_MSB:NOTE_LSB] = note_next;
        bus_next[OCT_MSB:OCT_LSB]   = oct_next;
    end

    // Registered outputs; note_change flags the cycle the new value appears
    always_ff @(posedge clk) begin
        if (rst) begin
            busline     <= {{NOTE_W{1'b0}}, OCT_MID};
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else begin
            busline     <= bus_next;
            note_valid  <= |note_next;
            note_change <= (bus_next != busline);
        end
    end

endmodule

// File: tb/tb_key_bus_encoder.sv
// ---------------------------------------------------------------------------
// tb_key_bus_encoder
// Self-checking bench for key_bus_encoder with DEBOUNCE_CYCLES = 4.
// A reference model predicts every new busline value from the raw inputs and
// queues it with the cycle it must appear; a monitor pops on each
// note_change pulse.  Directed checks cover reset, latency, glitches,
// priority, octave saturation and reset mid-debounce; a random phase follows.
// ---------------------------------------------------------------------------
module tb_key_bus_encoder;

    localparam int N = 4;

    typedef struct packed {
        logic [9:0] bus;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] note_sw;
    logic       oct_up_btn;
    logic       oct_down_btn;
    logic [9:0] busline;
    logic       note_valid;
    logic       note_change;

    int   checks;
    int   errors;
    int   cyc;
    int   pulse_count;
    exp_t exp_q [$];

    // Reference model state
    logic [8:0] hist [$];
    logic [8:0] m_deb;
    logic [8:0] m_deb_prev;
    int         m_oct;
    logic [9:0] m_bus;

    key_bus_encoder #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .note_sw      (note_sw),
        .oct_up_btn   (oct_up_btn),
        .oct_down_btn (oct_down_btn),
        .busline      (busline),
        .note_valid   (note_valid),
        .note_change  (note_change)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lowest pressed note as a one-hot field, found by scanning upward
    function automatic logic [6:0] ref_note(input logic [6:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] ref_oct(input int o);
        logic [2:0] r;
        r = '0;
        r[o] = 1'b1;
        return r;
    endfunction

    // Reference model: an input's debounced value becomes v whenever the raw
    // input has been sampled at v for N consecutive cycles, seen two cycles
    // late through the synchronizer.  The bus follows one cycle later.
    initial begin
        logic [9:0] new_bus;
        logic       up_rise;
        logic       dn_rise;
        logic       same;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                hist.delete();
                for (int i = 0; i < N + 2; i++) hist.push_back(9'b0);
                m_deb      = '0;
                m_deb_prev = '0;
                m_oct      = 1;
                m_bus      = 10'b0000000010;
                exp_q.delete();
            end else begin
                up_rise = m_deb[7] & ~m_deb_prev[7];
                dn_rise = m_deb[8] & ~m_deb_prev[8];
                if (up_rise && !dn_rise && m_oct < 2) m_oct++;
                if (dn_rise && !up_rise && m_oct > 0) m_oct--;
                new_bus = {ref_note(m_deb[6:0]), ref_oct(m_oct)};
                if (new_bus != m_bus) exp_q.push_back('{bus: new_bus, cyc: cyc});
                m_bus      = new_bus;
                m_deb_prev = m_deb;
                hist.push_back({oct_down_btn, oct_up_btn, note_sw});
                void'(hist.pop_front());
                for (int b = 0; b < 9; b++) begin
                    same = 1'b1;
                    for (int i = 1; i < N; i++) begin
                        if (hist[i][b] != hist[0][b]) same = 1'b0;
                    end
                    if (same) m_deb[b] = hist[0][b];
                end
            end
        end
    end

    // Monitor: every note_change pulse must match the next predicted value
    // in both content and cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (note_change === 1'b1) begin
                pulse_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL note_change_unexpected cycle=%0d busline=%b required no pulse", cyc, busline);
                end else begin
                    e = exp_q.pop_front();
                    if (busline !== e.bus || note_valid !== (|e.bus[9:3]) || e.cyc != cyc) begin
                        errors++;
                        $display("[TB] FAIL scoreboard cycle=%0d busline=%b note_valid=%b required busline=%b note_valid=%b at cycle %0d",
                                 cyc, busline, note_valid, e.bus, |e.bus[9:3], e.cyc);
                    end
                end
            end
        end
    end

    // Advance n rising edges and settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] notes, input logic up, input logic dn, input int cycles);
        note_sw      = notes;
        oct_up_btn   = up;
        oct_down_btn = dn;
        step(cycles);
    endtask

    task automatic checkOutput(input string name, input logic [9:0] exp_bus,
                               input logic exp_valid, input logic exp_change);
        checks++;
        if (busline !== exp_bus || note_valid !== exp_valid || note_change !== exp_change) begin
            errors++;
            $display("[TB] FAIL %s busline=%b note_valid=%b note_change=%b required busline=%b note_valid=%b note_change=%b",
                     name, busline, note_valid, note_change, exp_bus, exp_valid, exp_change);
        end
    endtask

    task automatic checkPulses(input string name, input int expected);
        checks++;
        if (pulse_count != expected) begin
            errors++;
            $display("[TB] FAIL %s note_change pulses=%0d required %0d", name, pulse_count, expected);
        end
    endtask

    // Wait (bounded) for all predicted bus changes to have been seen
    task automatic drain(input string name);
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s pending_changes=%0d required 0", name, exp_q.size());
        end
    endtask

    // Main stimulus sequence
    initial begin
        int pc;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        pulse_count  = 0;
        rst          = 1'b1;
        note_sw      = '0;
        oct_up_btn   = 1'b0;
        oct_down_btn = 1'b0;

        step(3);
        checkOutput("reset_hold", 10'b0000000010, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        checkOutput("reset_release", 10'b0000000010, 1'b0, 1'b0);

        // Raw-to-bus latency: new value visible after exactly 7 edges
        applyStimulus(7'b0000001, 1'b0, 1'b0, 6);
        checkOutput("latency_before", 10'b0000000010, 1'b0, 1'b0);
        step(1);
        checkOutput("latency_edge", 10'b0000001010, 1'b1, 1'b1);
        step(1);
        checkOutput("change_one_cycle", 10'b0000001010, 1'b1, 1'b0);
        drain("latency_drain");

        // Glitch shorter than the debounce window is ignored
        pc = pulse_count;
        applyStimulus(7'b0001001, 1'b0, 1'b0, 3);
        applyStimulus(7'b0000001, 1'b0, 1'b0, 20);
        checkOutput("glitch_ignored", 10'b0000001010, 1'b1, 1'b0);
        checkPulses("glitch_no_pulse", pc);

        // Lowest index wins
        applyStimulus(7'b1000100, 1'b0, 1'b0, 12);
        drain("priority_drain");
        checkOutput("lowest_wins", 10'b0000100010, 1'b1, 1'b0);

        // Three long up presses from MID saturate at HIGH
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'b1000100, 1'b1, 1'b0, 1000);
            applyStimulus(7'b1000100, 1'b0, 1'b0, 20);
            checkOutput($sformatf("oct_up_%0d", i), 10'b0000100100, 1'b1, 1'b0);
        end
        applyStimulus(7'b1000100, 1'b0, 1'b1, 1000);
        applyStimulus(7'b1000100, 1'b0, 1'b0, 20);
        checkOutput("oct_down_mid", 10'b0000100010, 1'b1, 1'b0);
        applyStimulus(7'b1000100, 1'b0, 1'b1, 1000);
        applyStimulus(7'b1000100, 1'b0, 1'b0, 20);
        checkOutput("oct_down_low", 10'b0000100001, 1'b1, 1'b0);
        applyStimulus(7'b1000100, 1'b0, 1'b1, 30);
        applyStimulus(7'b1000100, 1'b0, 1'b0, 20);
        checkOutput("oct_down_sat", 10'b0000100001, 1'b1, 1'b0);

        // Back to MID, then simultaneous up and down leave it alone
        applyStimulus(7'b1000100, 1'b1, 1'b0, 30);
        applyStimulus(7'b1000100, 1'b0, 1'b0, 20);
        applyStimulus(7'b1000100, 1'b1, 1'b1, 30);
        applyStimulus(7'b1000100, 1'b0, 1'b0, 20);
        checkOutput("simultaneous", 10'b0000100010, 1'b1, 1'b0);
        drain("octave_drain");

        // Reset during a pending note change discards it
        applyStimulus(7'b0010000, 1'b0, 1'b0, 3);
        rst = 1'b1;
        step(2);
        checkOutput("reset_mid_debounce", 10'b0000000010, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        checkOutput("after_reset", 10'b0000000010, 1'b0, 1'b0);
        step(10);
        checkOutput("held_note_after_reset", 10'b0010000010, 1'b1, 1'b0);

        // A button held through reset counts as a fresh press
        oct_up_btn = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(12);
        checkOutput("held_button_after_reset", 10'b0010000100, 1'b1, 1'b0);
        applyStimulus(7'b0010000, 1'b0, 1'b0, 20);
        drain("reset_drain");

        // Random phase, including glitches and overlapping button activity
        for (int i = 0; i < 80; i++) begin
            applyStimulus(7'($urandom_range(0, 127)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          $urandom_range(1, 12));
        end
        applyStimulus(7'b0000000, 1'b0, 1'b0, 20);
        drain("random_drain");
        checkOutput("random_end_no_note", {7'b0, ref_oct(m_oct)}, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
